// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the RV32I pipeline.
// Generates sequential PCs and issues pipelined requests on a valid/ready
// instruction-memory port. Responses land in a PC-tagged FIFO that feeds
// decode through a valid/ready handshake. A redirect flushes the buffer and
// discards responses to requests still in flight.
//
// Ports:
//   clk, reset_F          clock (rising edge), async active-high reset
//   redirect, redirect_pc branch/jump/flush and its target (bits [1:0] ignored)
//   imem_req_*            request channel; imem_addr is the current fetch PC
//   imem_rsp_*            in-order response channel, never back-pressured
//   instr_valid/ready     decode handshake; instr/instr_pc/instr_pc_plus4 = head
//   fifo_count, inflight  buffered entries / issued-but-unanswered requests
module fetch_unit #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4,
  localparam int unsigned      CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_F,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [CW-1:0]   fifo_count,
  output logic [CW-1:0]   inflight
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard;

  // PCs of live (non-stale) outstanding requests, in issue order
  logic [XLEN-1:0] pcq_mem [DEPTH];
  logic [AW-1:0]   pcq_wr;
  logic [AW-1:0]   pcq_rd;

  // Instruction buffer: {pc, data} per entry
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   fifo_wr;
  logic [AW-1:0]   fifo_rd;

  logic            issue;
  logic            drop;
  logic            accept;
  logic            deq;
  logic [CW:0]     credit_used;

  // Low target bits are forced to zero, so they are intentionally unused
  logic            unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Handshake decode; credits cover both buffered and in-flight entries
  always_comb begin
    credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    imem_req_valid = ~reset_F & ~redirect & (credit_used < (CW+1)'(DEPTH));
    issue          = imem_req_valid & imem_req_ready;
    drop           = imem_rsp_valid & (redirect | (discard != '0));
    accept         = imem_rsp_valid & ~drop;
    instr_valid    = (fifo_count != '0);
    deq            = instr_valid & instr_ready & ~redirect;
  end

  assign imem_addr      = fetch_pc;
  assign instr          = fifo_data[fifo_rd];
  assign instr_pc       = fifo_pc[fifo_rd];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);

  // Control state: PC, counters and queue pointers
  always_ff @(posedge clk or posedge reset_F) begin
    if (reset_F) begin
      fetch_pc   <= RESET_PC;
      inflight   <= '0;
      fifo_count <= '0;
      discard    <= '0;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Everything still outstanding after this cycle's response is stale
        fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
        discard    <= inflight - CW'(imem_rsp_valid);
        fifo_count <= '0;
        pcq_wr     <= '0;
        pcq_rd     <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          pcq_wr   <= pcq_wr + AW'(1);
        end
        if (accept) begin
          pcq_rd  <= pcq_rd + AW'(1);
          fifo_wr <= fifo_wr + AW'(1);
        end
        if (deq) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        if (drop) begin
          discard <= discard - CW'(1);
        end
        fifo_count <= fifo_count + CW'(accept) - CW'(deq);
      end
    end
  end

  // Storage arrays carry no reset; contents are only meaningful when counted
  always_ff @(posedge clk) begin
    if (issue) begin
      pcq_mem[pcq_wr] <= fetch_pc;
    end
    if (accept) begin
      fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
      fifo_data[fifo_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit with an in-order
// memory model and a transaction-level model of the instruction stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          reset_F;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [31:0]   instr_pc_plus4;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_F(reset_F),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .fifo_count(fifo_count), .inflight(inflight)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        mem_q[$];     // requests accepted by memory, not yet answered
  logic [31:0] mfifo[$];     // PCs expected in the decode buffer, head first
  logic [31:0] exp_issue_pc;
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          checks;
  int          failures;
  int          delivered;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check, advance the model at posedge
  task automatic step(input bit redir, input logic [31:0] rpc,
                      input bit rdy_i, input bit rdy_m);
    bit   rsp, acc, deq, exp_rv;
    req_t r;
    int   d;
    redirect       = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy_i;
    imem_req_ready = rdy_m;
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (mem_q[0].addr ^ 32'h0000A5A5) : $urandom;
    #1;
    exp_rv = !redir && ((mem_q.size() + mfifo.size()) < DEPTH);
    chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("imem_addr", imem_addr, exp_issue_pc);
    chk("inflight", 32'(inflight), 32'(mem_q.size()));
    chk("fifo_count", 32'(fifo_count), 32'(mfifo.size()));
    chk("instr_valid", 32'(instr_valid), 32'(mfifo.size() != 0));
    if (mfifo.size() != 0) begin
      chk("instr_pc", instr_pc, mfifo[0]);
      chk("instr", instr, mfifo[0] ^ 32'h0000A5A5);
      chk("instr_pc_plus4", instr_pc_plus4, mfifo[0] + 32'd4);
    end
    acc = exp_rv && rdy_m;
    deq = (mfifo.size() != 0) && rdy_i && !redir;
    @(posedge clk);
    if (deq) begin
      void'(mfifo.pop_front());
      delivered++;
    end
    if (rsp) begin
      r = mem_q.pop_front();
      if (!r.stale && !redir) mfifo.push_back(r.addr);
    end
    if (acc) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{exp_issue_pc, d, 1'b0});
      exp_issue_pc = exp_issue_pc + 32'd4;
    end
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      mfifo.delete();
      exp_issue_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
  endtask

  task automatic model_reset();
    mem_q.delete();
    mfifo.delete();
    exp_issue_pc = 32'h0;
    last_due     = cyc;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; last_due = -1; delivered = 0;
    lat_min = 1; lat_max = 1;
    reset_F = 1'b1; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_F = 1'b0;

    // 1-cycle memory, full throughput
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);
    chk("throughput_delivered", 32'(delivered >= 9), 32'h1);

    // Decode stalled: buffer fills to DEPTH, issue stops, then drains in order
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);
    chk("stall_fifo_full", 32'(fifo_count), 32'(DEPTH));
    chk("stall_no_issue", 32'(imem_req_valid), 32'h0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with response and dequeue
    step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    chk("redir_fifo_empty", 32'(fifo_count), 32'h0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // 3-cycle memory, redirect with requests in flight
    lat_min = 3; lat_max = 3;
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);

    // Wrap-around target and back-to-back redirects
    lat_min = 1; lat_max = 2;
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0203, 1'b1, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset with a loaded buffer and requests outstanding
    lat_min = 2; lat_max = 2;
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    chk("pre_reset_loaded", 32'(fifo_count != 0), 32'h1);
    redirect = 1'b0; imem_rsp_valid = 1'b0;
    #2 reset_F = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset_F = 1'b0;
    model_reset();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic
    for (int ph = 0; ph < 5; ph++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      for (int k = 0; k < 100; k++) begin
        bit          rd;
        logic [31:0] tgt;
        rd  = ($urandom_range(15, 0) == 0);
        tgt = $urandom;
        if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        step(rd, tgt, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
